// File: rtl/pc_sequencer.sv
// Program counter with relative branch, absolute jump and a call/return stack; one action per cycle.
// Latency: controls sampled at posedge, effect on addr/depth next cycle; no backpressure, halt freezes state.
module pc_sequencer #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               halt,
    input  logic                               branch,
    input  logic [PC_W-1:0]                    offset,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [PC_W-1:0]                    target,
    output logic [PC_W-1:0]                    addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               fault,
    output logic                               fault_ovf
);
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]   depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic [PC_W-1:0]    stack_q [STACK_DEPTH];
    logic [PC_W-1:0]    stack_d [STACK_DEPTH];
    logic [PC_W-1:0]    top_val;
    logic [PC_W-1:0]    pc_inc;

    assign pc_inc = pc_q + PC_W'(1);

    // Select stack[depth-1] without a variable index that could run past the array.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (PTR_W'(i + 1) == depth_q) begin
                top_val = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        stack_d = stack_q;
        if (state_q == S_RUN && !halt) begin
            if (ret) begin
                if (depth_q == '0) begin
                    state_d = S_FAULT;
                    ovf_d   = 1'b0;
                end else begin
                    pc_d    = top_val;
                    depth_d = depth_q - PTR_W'(1);
                end
            end else if (call) begin
                if (depth_q == PTR_W'(STACK_DEPTH)) begin
                    state_d = S_FAULT;
                    ovf_d   = 1'b1;
                end else begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (PTR_W'(i) == depth_q) begin
                            stack_d[i] = pc_inc;
                        end
                    end
                    depth_d = depth_q + PTR_W'(1);
                    pc_d    = target;
                end
            end else if (jump) begin
                pc_d = target;
            end else if (branch) begin
                // Modulo-2^PC_W add of a two's-complement offset is the sign-extended add.
                pc_d = pc_q + offset;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
        if (!reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
        end
    end

    assign addr      = pc_q;
    assign depth     = depth_q;
    assign fault     = (state_q == S_FAULT);
    assign fault_ovf = ovf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized controls against a queue-based reference model.
module tb_pc_sequencer;
    localparam int PC_W  = 8;
    localparam int SD    = 4;
    localparam int PW    = $clog2(SD + 1);
    localparam int unsigned MASK = (1 << PC_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, halt, branch, jump, call, ret;
    logic [PC_W-1:0] offset, target, addr;
    logic [PW-1:0]   depth;
    logic            fault, fault_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_pc    = 0;
    int unsigned m_stack [$];
    bit          m_fault = 0;
    bit          m_ovf   = 0;

    pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .halt      (halt),
        .branch    (branch),
        .offset    (offset),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .addr      (addr),
        .depth     (depth),
        .fault     (fault),
        .fault_ovf (fault_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_step();
        if (!reset) begin
            m_pc = 0;
            m_stack.delete();
            m_fault = 0;
            m_ovf = 0;
        end else if (m_fault || halt) begin
        end else if (ret) begin
            if (m_stack.size() == 0) begin
                m_fault = 1;
                m_ovf = 0;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (call) begin
            if (m_stack.size() == SD) begin
                m_fault = 1;
                m_ovf = 1;
            end else begin
                m_stack.push_back((m_pc + 1) & MASK);
                m_pc = int'(target);
            end
        end else if (jump) begin
            m_pc = int'(target);
        end else if (branch) begin
            m_pc = int'(unsigned'(int'(m_pc) + int'($signed(offset)))) & MASK;
        end else begin
            m_pc = (m_pc + 1) & MASK;
        end
    endfunction

    task automatic cyc(input string tag, input bit rs, input bit h, input bit br, input logic [7:0] off,
                       input bit j, input bit c, input bit r, input logic [7:0] tg);
        reset = rs; halt = h; branch = br; offset = off; jump = j; call = c; ret = r; target = tg;
        @(posedge clk);
        #1;
        model_step();
        check_eq({tag, ".addr"},  32'(addr),      32'(m_pc));
        check_eq({tag, ".depth"}, 32'(depth),     32'(m_stack.size()));
        check_eq({tag, ".fault"}, 32'(fault),     32'(m_fault));
        check_eq({tag, ".ovf"},   32'(fault_ovf), 32'(m_ovf));
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset(input string tag);
        cyc(tag, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    initial begin
        reset = 0; halt = 0; branch = 0; offset = '0; jump = 0; call = 0; ret = 0; target = '0;

        // 1: reset then free-running increment
        do_reset("rst0");
        do_reset("rst1");
        check_eq("t1.addr_rst", 32'(addr), 0);
        check_eq("t1.depth_rst", 32'(depth), 0);
        check_eq("t1.fault_rst", 32'(fault), 0);
        for (int i = 1; i <= 4; i++) begin
            idle("t1.run");
            check_eq("t1.addr_seq", 32'(addr), 32'(i));
        end

        // 2: branches and wrap
        cyc("t2.jmp", 1, 0, 0, 8'h00, 1, 0, 0, 8'd10);
        cyc("t2.bneg", 1, 0, 1, 8'hFD, 0, 0, 0, 8'h00);
        check_eq("t2.bneg_val", 32'(addr), 7);
        cyc("t2.jmp2", 1, 0, 0, 8'h00, 1, 0, 0, 8'd10);
        cyc("t2.bpos", 1, 0, 1, 8'h05, 0, 0, 0, 8'h00);
        check_eq("t2.bpos_val", 32'(addr), 15);
        cyc("t2.jmp255", 1, 0, 0, 8'h00, 1, 0, 0, 8'd255);
        idle("t2.wrap");
        check_eq("t2.wrap_val", 32'(addr), 0);
        cyc("t2.bwrap", 1, 0, 1, 8'hFF, 0, 0, 0, 8'h00);
        check_eq("t2.bwrap_val", 32'(addr), 255);

        // 3: nested call/return
        cyc("t3.jmp", 1, 0, 0, 8'h00, 1, 0, 0, 8'd20);
        cyc("t3.call1", 1, 0, 0, 8'h00, 0, 1, 0, 8'd100);
        check_eq("t3.call1_addr", 32'(addr), 100);
        idle("t3.inc");
        check_eq("t3.inc_addr", 32'(addr), 101);
        cyc("t3.call2", 1, 0, 0, 8'h00, 0, 1, 0, 8'd200);
        check_eq("t3.call2_depth", 32'(depth), 2);
        cyc("t3.ret1", 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
        check_eq("t3.ret1_addr", 32'(addr), 102);
        cyc("t3.ret2", 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
        check_eq("t3.ret2_addr", 32'(addr), 21);
        check_eq("t3.ret2_depth", 32'(depth), 0);

        // 4: overflow fault, frozen, cleared by reset
        for (int i = 0; i < SD; i++) cyc("t4.call", 1, 0, 0, 8'h00, 0, 1, 0, 8'(30 + 10 * i));
        cyc("t4.ovf", 1, 0, 0, 8'h00, 0, 1, 0, 8'd70);
        check_eq("t4.fault", 32'(fault), 1);
        check_eq("t4.fault_ovf", 32'(fault_ovf), 1);
        check_eq("t4.frozen_addr", 32'(addr), 60);
        check_eq("t4.frozen_depth", 32'(depth), 4);
        cyc("t4.jmp_ign", 1, 0, 0, 8'h00, 1, 0, 0, 8'd5);
        cyc("t4.br_ign", 1, 0, 1, 8'h03, 0, 0, 0, 8'h00);
        check_eq("t4.still_frozen", 32'(addr), 60);
        do_reset("t4.rst");
        check_eq("t4.rst_fault", 32'(fault), 0);
        check_eq("t4.rst_depth", 32'(depth), 0);

        // 5: halt masks underflow; bare ret underflows
        cyc("t5.halt_ret", 1, 1, 0, 8'h00, 0, 0, 1, 8'h00);
        check_eq("t5.halt_nofault", 32'(fault), 0);
        check_eq("t5.halt_addr", 32'(addr), 0);
        cyc("t5.udf", 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
        check_eq("t5.udf_fault", 32'(fault), 1);
        check_eq("t5.udf_ovf", 32'(fault_ovf), 0);
        check_eq("t5.udf_addr", 32'(addr), 0);
        do_reset("t5.rst");

        // 6: call+ret together pops only; reset mid-sequence
        cyc("t6.call", 1, 0, 0, 8'h00, 0, 1, 0, 8'd50);
        cyc("t6.callret", 1, 0, 0, 8'h00, 0, 1, 1, 8'd99);
        check_eq("t6.cr_addr", 32'(addr), 1);
        check_eq("t6.cr_depth", 32'(depth), 0);
        cyc("t6.call2", 1, 0, 0, 8'h00, 0, 1, 0, 8'd80);
        cyc("t6.rst_mid", 0, 0, 0, 8'h00, 0, 1, 0, 8'd90);
        check_eq("t6.rst_addr", 32'(addr), 0);
        check_eq("t6.rst_depth", 32'(depth), 0);

        // Randomized controls
        for (int n = 0; n < 3000; n++) begin
            cyc("rnd",
                $urandom_range(0, 39) != 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0,
                8'($urandom),
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0,
                8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
